// File: rtl/id_pkg.sv
// Shared definitions for the identifier scanner: recognizer/controller state encodings,
// ASCII class boundaries and character-class helpers.
package id_pkg;

    typedef enum logic [1:0] {
        ST_ERROR = 2'd0,
        ST_ALPHA = 2'd1,
        ST_DIGIT = 2'd2
    } id_state_e;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_SCAN = 2'd1,
        C_DONE = 2'd2
    } ctrl_state_e;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_9 = 8'h39;
    localparam logic [7:0] UPPER_A = 8'h41;
    localparam logic [7:0] UPPER_Z = 8'h5A;
    localparam logic [7:0] LOWER_A = 8'h61;
    localparam logic [7:0] LOWER_Z = 8'h7A;

    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= UPPER_A) && (c <= UPPER_Z)) || ((c >= LOWER_A) && (c <= LOWER_Z));
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= ASCII_0) && (c <= ASCII_9);
    endfunction

endpackage

// File: rtl/id_match_core.sv
// Registered identifier recognizer; match flags a byte whose next state is DIGIT (combinational).
// clr overrides en and returns the recognizer to ERROR.
module id_match_core
    import id_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic [7:0] char,
    output id_state_e  state,
    output logic       match
);

    id_state_e state_q;
    id_state_e state_d;
    id_state_e next_st;

    always_comb begin
        next_st = ST_ERROR;
        if (is_letter(char)) begin
            next_st = ST_ALPHA;
        end else if (is_digit(char)) begin
            // Unused encodings fall through to ERROR like ERROR itself
            case (state_q)
                ST_ALPHA, ST_DIGIT: next_st = ST_DIGIT;
                default:            next_st = ST_ERROR;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_ERROR;
        end else if (en) begin
            state_d = next_st;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ERROR;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
    assign match = (next_st == ST_DIGIT);

endmodule

// File: rtl/id_scan_ctrl.sv
// Buffers a byte string, replays it into the recognizer one byte per cycle on start, and
// reports the DIGIT-position count and first such index with a registered done pulse.
module id_scan_ctrl
    import id_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] match_cnt,
    output logic          hit,
    output logic [AW-1:0] first_hit
);

    logic [7:0]    mem_q [DEPTH];
    ctrl_state_e   state_q, state_d;
    logic [CW-1:0] len_q, len_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit_q, hit_d;
    logic [AW-1:0] first_q, first_d;
    logic          done_q, done_d;
    logic          wr_accept;
    logic          core_en, core_clr, core_match;
    id_state_e     core_state;

    assign full = (len_q == CW'(DEPTH));

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        hit_d     = hit_q;
        first_d   = first_q;
        done_d    = 1'b0;
        wr_accept = 1'b0;
        core_en   = 1'b0;
        core_clr  = 1'b0;
        case (state_q)
            C_IDLE: begin
                // start takes priority: a write in the same cycle is dropped
                if (start) begin
                    state_d  = (len_q != '0) ? C_SCAN : C_DONE;
                    rd_ptr_d = '0;
                    core_clr = 1'b1;
                    cnt_d    = '0;
                    hit_d    = 1'b0;
                    first_d  = '1;
                end else if (wr_en && !full) begin
                    wr_accept = 1'b1;
                    len_d     = len_q + CW'(1);
                    wr_ptr_d  = wr_ptr_q + AW'(1);
                end
            end
            C_SCAN: begin
                core_en = 1'b1;
                if (core_match) begin
                    cnt_d = cnt_q + CW'(1);
                    if (!hit_q) begin
                        first_d = rd_ptr_q;
                        hit_d   = 1'b1;
                    end
                end
                if (CW'(rd_ptr_q) == len_q - CW'(1)) begin
                    state_d = C_DONE;
                end else begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                end
            end
            C_DONE: begin
                done_d   = 1'b1;
                len_d    = '0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                state_d  = C_IDLE;
            end
            default: state_d = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= C_IDLE;
            len_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            hit_q    <= 1'b0;
            first_q  <= '1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            hit_q    <= hit_d;
            first_q  <= first_d;
            done_q   <= done_d;
        end
    end

    // Storage needs no reset: len_q alone defines which entries are valid
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    id_match_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (core_en),
        .clr   (core_clr),
        .char  (mem_q[rd_ptr_q]),
        .state (core_state),
        .match (core_match)
    );

    assign busy      = (state_q != C_IDLE);
    assign done      = done_q;
    assign match_cnt = cnt_q;
    assign hit       = hit_q;
    assign first_hit = first_q;

endmodule

// File: tb/tb_id_scan_ctrl.sv
// Scoreboard bench for id_scan_ctrl: directed strings, expected results queued at start,
// popped and compared by an independent monitor whenever done pulses.
module tb_id_scan_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          start;
    logic          busy;
    logic          done;
    logic [CW-1:0] match_cnt;
    logic          hit;
    logic [AW-1:0] first_hit;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic          hit;
        logic [AW-1:0] first;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    id_scan_ctrl #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .match_cnt (match_cnt),
        .hit       (hit),
        .first_hit (first_hit)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("match_cnt", int'(match_cnt), int'(e.cnt));
                chk("hit", int'(hit), int'(e.hit));
                chk("first_hit", int'(first_hit), int'(e.first));
            end
        end
    end

    task automatic write_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            wr_en   = 1'b1;
            wr_data = s[i];
            @(negedge clk);
        end
        wr_en = 1'b0;
    endtask

    task automatic do_scan(input int ec, input int eh, input int ef, input int elat,
                           input int ebusy, input bit with_wr, input bit noise);
        exp_t e;
        int   n, nb;
        bit   got;
        e.cnt   = ec[CW-1:0];
        e.hit   = eh[0];
        e.first = ef[AW-1:0];
        exp_q.push_back(e);
        start = 1'b1;
        if (with_wr) begin
            wr_en   = 1'b1;
            wr_data = "q";
        end
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        n = 0; nb = 0; got = 1'b0;
        while (n < 200 && !got) begin
            if (busy) nb++;
            if (done) begin
                got = 1'b1;
            end else begin
                if (noise) begin
                    wr_en   = busy;
                    start   = busy;
                    wr_data = "5";
                end
                @(negedge clk);
                n++;
            end
        end
        wr_en = 1'b0;
        start = 1'b0;
        if (!got) begin
            chk("scan_timeout", 0, 1);
        end else begin
            chk("latency", n, elat);
            chk("busy_cycles", nb, ebusy);
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        start   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_full", int'(full), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cnt", int'(match_cnt), 0);
        chk("rst_hit", int'(hit), 0);
        chk("rst_first", int'(first_hit), 15);
        rst_n = 1'b1;
        @(negedge clk);

        write_str("a1b2");
        do_scan(2, 1, 1, 5, 5, 1'b0, 1'b0);
        write_str("ab12;c3");
        do_scan(3, 1, 2, 8, 8, 1'b0, 1'b0);
        write_str("1a");
        do_scan(0, 0, 15, 3, 3, 1'b0, 1'b0);
        write_str("9;__");
        do_scan(0, 0, 15, 5, 5, 1'b0, 1'b0);

        do_scan(0, 0, 15, 1, 1, 1'b1, 1'b0);
        chk("start_wr_full", int'(full), 0);
        do_scan(0, 0, 15, 1, 1, 1'b0, 1'b0);

        write_str("a111111111111111");
        chk("full_at_16", int'(full), 1);
        write_str("7");
        chk("full_after_drop", int'(full), 1);
        do_scan(15, 1, 1, 17, 17, 1'b0, 1'b1);
        chk("full_after_scan", int'(full), 0);

        write_str("x9");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_cnt", int'(match_cnt), 0);
        chk("abort_hit", int'(hit), 0);
        chk("abort_first", int'(first_hit), 15);
        chk("abort_full", int'(full), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        write_str("z0");
        do_scan(1, 1, 1, 3, 3, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_scan_ctrl.md
# id_scan_ctrl

Buffered scan controller for the identifier recognizer. A producer loads a string of up to DEPTH bytes through a write port. On `start`, the block replays the string one byte per cycle into an internal identifier-recognition core. It counts the positions at which the recognizer sits in its "identifier ending in a digit" state, and reports the count and the first such position with a one-cycle `done` pulse. It sits between a byte-stream source and any consumer needing per-string identifier statistics.

## Interface
Parameters:
- DEPTH, 16, string buffer capacity in bytes; power of two, at least 2
- AW, $clog2(DEPTH), buffer address width
- CW, $clog2(DEPTH+1), width of length and count fields

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write one byte into the buffer (honoured only in IDLE)
- wr_data  in  8  ASCII byte to store
- full  out  1  buffer holds DEPTH bytes
- start  in  1  begin a scan of the buffered string (honoured only in IDLE)
- busy  out  1  high in SCAN and DONE
- done  out  1  one-cycle pulse; results valid from this cycle
- match_cnt  out  CW  number of scanned positions classified DIGIT
- hit  out  1  at least one DIGIT position occurred
- first_hit  out  AW  index of the first DIGIT position; all-ones when hit=0

## Operation
- Character classes: letter is 0x41–0x5A or 0x61–0x7A; digit is 0x30–0x39; every other byte is "other".
- Recognizer states, encoded in a shared package: ERROR=0, ALPHA=1, DIGIT=2.
  - letter: any state -> ALPHA
  - digit: ALPHA or DIGIT -> DIGIT; ERROR -> ERROR
  - other: any state -> ERROR
  - unused encoding -> ERROR
- A position is a match when the recognizer's next state after consuming that byte is DIGIT.
- Controller FSM states:
  - IDLE:
    - wr_en && !full: store wr_data at wr_ptr; increment len and wr_ptr.
    - wr_en while full: write dropped, no state change.
    - start && len>0: go to SCAN; rd_ptr=0; core forced to ERROR; match_cnt=0; hit=0; first_hit=all-ones.
    - start && len==0: go to DONE with zero results.
    - start and wr_en in the same cycle: start wins; the byte is dropped.
  - SCAN:
    - Each cycle, feed buf[rd_ptr] to the core.
    - On a match: match_cnt+1; if hit=0, set first_hit=rd_ptr and hit=1.
    - rd_ptr==len-1: go to DONE. Otherwise increment rd_ptr.
  - DONE: assert done for one cycle; clear len, wr_ptr and rd_ptr (buffer emptied); go to IDLE.
- In SCAN and DONE, wr_en and start are ignored.
- match_cnt, hit and first_hit hold their values until the next accepted start.
- match_cnt cannot overflow: at most DEPTH matches, which fits in CW bits.

## Timing
- Reset (async assert, sync release) gives:
  - state IDLE, len 0, core ERROR
  - full=0, busy=0, done=0
  - match_cnt=0, hit=0, first_hit=all-ones
- Write: accepted on the clk edge where wr_en=1. `full` updates on that same edge.
- Scan latency: start is sampled at edge 0. Bytes are consumed at edges 1..L. done=1 during the cycle after edge L+1. For an empty string, done follows start by one cycle.
- busy rises the cycle after start is accepted and falls together with done.
- Results are registered. They are stable and valid when done=1.
- Reset asserted mid-scan aborts the scan immediately. The buffer is emptied and no done is produced.

## Structure
- Shared package id_pkg holds:
  - recognizer state typedef and encodings (ERROR/ALPHA/DIGIT)
  - ASCII range constants
  - is_letter / is_digit functions
- Sub-module id_match_core: registered recognizer with inputs clk, rst_n, en, clr and char[7:0]; outputs state and match (combinational next==DIGIT). clr overrides en and forces ERROR.
- Controller, buffer (register array) and counters live in id_scan_ctrl.

## Test plan
- Reset, write "a1b2", start -> done at 5 cycles after start; match_cnt=2; hit=1; first_hit=1.
- Write "ab12;c3", start -> match_cnt=3 (positions 2, 3, 6); first_hit=2; busy high for exactly 8 cycles.
- Write "1a", start -> match_cnt=0; hit=0; first_hit=4'hF. Same for "9;__".
- Start with an empty buffer -> done one cycle later; match_cnt=0; hit=0. Start and wr_en in the same cycle -> write dropped, len stays 0.
- Write 17 bytes "a" followed by 15×"1" plus an extra "7" -> full after 16; the 17th byte is dropped; match_cnt=15; first_hit=1. Writes and start during SCAN are ignored.
- Deassert rst_n during SCAN of "x9" -> outputs return to reset values, no done pulse. A new "z0" load and scan then yields match_cnt=1.
